// File: rtl/mem_port_arb_pkg.sv
// Shared types for the memory-port arbiter: FSM states, the default-width pending request
// and the beat-count rule.
package mem_port_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } arb_state_e;

    localparam int unsigned DefAddrWidth = 21;
    localparam int unsigned DefDataWidth = 16;
    localparam int unsigned DefDqmWidth  = 2;

    typedef struct packed {
        logic [DefAddrWidth-1:0] addr;
        logic [DefDataWidth-1:0] data;
        logic [DefDqmWidth-1:0]  byte_en;
        logic                    burst;
        logic                    is_write;
    } pending_req_t;

    // Only burst reads return more than one beat; writes always complete with one pulse.
    function automatic int unsigned beat_count(input logic burst, input logic is_write,
                                               input int unsigned burst_len);
        return (burst && !is_write) ? burst_len : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// Combinational rotate-priority arbiter: the search starts one past last_grant and wraps.
module rr_arbiter #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned IDX_WIDTH = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_WIDTH-1:0] last_grant,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IDX_WIDTH-1:0] grant_idx
);

    logic                 found;
    logic [IDX_WIDTH-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
            idx = IDX_WIDTH'((32'(last_grant) + k) % NUM_PORTS);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one downstream memory-controller port among NUM_PORTS requesters: per-port capture,
// round-robin grant, one transaction in flight, responses routed to the granted port only.
module mem_port_arbiter
    import mem_port_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS         = 4,
    parameter int unsigned PORT_ADDR_WIDTH   = 21,
    parameter int unsigned DATA_WIDTH        = 16,
    parameter int unsigned DQM_WIDTH         = 2,
    parameter int unsigned PORT_OUTPUT_WIDTH = 32,
    parameter int unsigned BURST_LEN         = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_PORTS*PORT_ADDR_WIDTH-1:0] s_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]      s_data,
    input  logic [NUM_PORTS*DQM_WIDTH-1:0]       s_byte_en,
    input  logic [NUM_PORTS-1:0]                 s_rd,
    input  logic [NUM_PORTS-1:0]                 s_wr,
    input  logic [NUM_PORTS-1:0]                 s_burst,
    output logic [NUM_PORTS-1:0]                 s_available,
    output logic [NUM_PORTS-1:0]                 s_ready,
    output logic [PORT_OUTPUT_WIDTH-1:0]         s_q,
    output logic [PORT_ADDR_WIDTH-1:0]           m_addr,
    output logic [DATA_WIDTH-1:0]                m_data,
    output logic [DQM_WIDTH-1:0]                 m_byte_en,
    output logic                                 m_rd,
    output logic                                 m_wr,
    output logic                                 m_burst,
    input  logic [PORT_OUTPUT_WIDTH-1:0]         m_q,
    input  logic                                 m_available,
    input  logic                                 m_ready
);

    localparam int unsigned IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned CW = $clog2(BURST_LEN + 1);

    typedef struct packed {
        logic [PORT_ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]      data;
        logic [DQM_WIDTH-1:0]       byte_en;
        logic                       burst;
        logic                       is_write;
    } port_req_t;

    arb_state_e           state_q, state_d;
    port_req_t            pend_q [NUM_PORTS];
    logic [NUM_PORTS-1:0] valid_q, valid_d, capture, done_mask;
    logic [NUM_PORTS-1:0] req_grant_oh, grant_oh_q;
    logic [IW-1:0]        req_grant_idx, grant_idx_q, last_grant_q;
    logic [CW-1:0]        cnt_q;
    logic                 is_write_q, burst_q;
    logic                 start, last_beat;

    rr_arbiter #(
        .NUM_PORTS(NUM_PORTS),
        .IDX_WIDTH(IW)
    ) u_rr_arbiter (
        .req       (valid_q),
        .last_grant(last_grant_q),
        .grant     (req_grant_oh),
        .grant_idx (req_grant_idx)
    );

    assign start     = (state_q == StIdle) && (|valid_q) && m_available;
    assign last_beat = (state_q == StWait) && m_ready && (cnt_q == CW'(1));
    assign done_mask = last_beat ? grant_oh_q : '0;

    // A port that is still pending drops new strobes; s_wr wins over s_rd.
    assign capture     = (s_rd | s_wr) & ~valid_q;
    assign valid_d     = (valid_q & ~done_mask) | capture;
    assign s_available = ~valid_q;
    assign s_q         = m_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                pend_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (capture[i]) begin
                    pend_q[i].addr     <= s_addr[i*PORT_ADDR_WIDTH +: PORT_ADDR_WIDTH];
                    pend_q[i].data     <= s_data[i*DATA_WIDTH +: DATA_WIDTH];
                    pend_q[i].byte_en  <= s_byte_en[i*DQM_WIDTH +: DQM_WIDTH];
                    pend_q[i].burst    <= s_burst[i];
                    pend_q[i].is_write <= s_wr[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait:  if (last_beat) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        m_rd    = 1'b0;
        m_wr    = 1'b0;
        m_burst = 1'b0;
        s_ready = '0;
        if (state_q == StIssue) begin
            m_rd    = !is_write_q;
            m_wr    = is_write_q;
            m_burst = burst_q;
        end
        if (state_q == StWait && m_ready) begin
            s_ready = grant_oh_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_addr       <= '0;
            m_data       <= '0;
            m_byte_en    <= '0;
            burst_q      <= 1'b0;
            is_write_q   <= 1'b0;
            grant_oh_q   <= '0;
            grant_idx_q  <= '0;
            last_grant_q <= IW'(NUM_PORTS - 1);
            cnt_q        <= '0;
        end else begin
            if (start) begin
                m_addr      <= pend_q[req_grant_idx].addr;
                m_data      <= pend_q[req_grant_idx].data;
                m_byte_en   <= pend_q[req_grant_idx].byte_en;
                burst_q     <= pend_q[req_grant_idx].burst;
                is_write_q  <= pend_q[req_grant_idx].is_write;
                grant_oh_q  <= req_grant_oh;
                grant_idx_q <= req_grant_idx;
            end
            if (state_q == StIssue) begin
                cnt_q <= CW'(beat_count(burst_q, is_write_q, BURST_LEN));
            end
            if (state_q == StWait && m_ready) begin
                cnt_q <= cnt_q - CW'(1);
            end
            if (last_beat) begin
                last_grant_q <= grant_idx_q;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked against a round-robin reference model.
module tb_mem_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 21;
    localparam int DW = 16;
    localparam int BW = 2;
    localparam int QW = 32;
    localparam int BL = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*AW-1:0] s_addr;
    logic [N*DW-1:0] s_data;
    logic [N*BW-1:0] s_byte_en;
    logic [N-1:0]    s_rd, s_wr, s_burst, s_available, s_ready;
    logic [QW-1:0]   s_q, m_q;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_data;
    logic [BW-1:0]   m_byte_en;
    logic            m_rd, m_wr, m_burst, m_available, m_ready;

    int checks = 0;
    int passed = 0;

    // Reference model: which ports hold a request, their fields, and who was served last.
    bit            pend_m [N];
    logic [AW-1:0] ex_addr [N];
    logic [DW-1:0] ex_data [N];
    logic [BW-1:0] ex_be [N];
    bit            ex_wr [N];
    bit            ex_burst [N];
    int            last_m;

    mem_port_arbiter #(
        .NUM_PORTS(N), .PORT_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DQM_WIDTH(BW),
        .PORT_OUTPUT_WIDTH(QW), .BURST_LEN(BL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .s_addr(s_addr), .s_data(s_data), .s_byte_en(s_byte_en),
        .s_rd(s_rd), .s_wr(s_wr), .s_burst(s_burst), .s_available(s_available),
        .s_ready(s_ready), .s_q(s_q), .m_addr(m_addr), .m_data(m_data),
        .m_byte_en(m_byte_en), .m_rd(m_rd), .m_wr(m_wr), .m_burst(m_burst), .m_q(m_q),
        .m_available(m_available), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        s_rd    = '0;
        s_wr    = '0;
        s_burst = '0;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        s_addr      = '0;
        s_data      = '0;
        s_byte_en   = '0;
        clear_strobes();
        m_q         = '0;
        m_ready     = 1'b0;
        m_available = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        last_m = N - 1;
        for (int p = 0; p < N; p++) pend_m[p] = 0;
    endtask

    // Drives a request on port p; the model records it only if the port is free.
    task automatic strobe(input int p, input bit wr, input bit burst, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [BW-1:0] be);
        s_addr[p*AW +: AW]    = a;
        s_data[p*DW +: DW]    = d;
        s_byte_en[p*BW +: BW] = be;
        if (wr) s_wr[p] = 1'b1;
        else    s_rd[p] = 1'b1;
        s_burst[p] = burst;
        if (!pend_m[p]) begin
            pend_m[p]   = 1;
            ex_addr[p]  = a;
            ex_data[p]  = d;
            ex_be[p]    = be;
            ex_wr[p]    = wr;
            ex_burst[p] = burst;
        end
    endtask

    task automatic wait_issue(output bit ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (m_rd || m_wr) begin
                ok = 1;
                break;
            end
            tick();
        end
    endtask

    function automatic int rr_pick();
        for (int k = 1; k <= N; k++) begin
            if (pend_m[(last_m + k) % N]) return (last_m + k) % N;
        end
        return -1;
    endfunction

    task automatic test_reset();
        do_reset();
        checks++; if (s_available !== 4'hF) $display("FAIL reset_avail got %b exp 1111", s_available); else passed++;
        checks++; if (s_ready !== 4'h0) $display("FAIL reset_ready got %b exp 0000", s_ready); else passed++;
        checks++; if ({m_rd, m_wr, m_burst} !== 3'b000) $display("FAIL reset_strobes got %b exp 000", {m_rd, m_wr, m_burst}); else passed++;
        checks++; if ({m_addr, m_data, m_byte_en} !== '0) $display("FAIL reset_fields got %h/%h/%h exp 0", m_addr, m_data, m_byte_en); else passed++;
    endtask

    task automatic test_single_write();
        do_reset();
        strobe(0, 1, 0, 21'h00123, 16'hBEEF, 2'b11);
        tick();
        clear_strobes();
        checks++; if (s_available !== 4'b1110) $display("FAIL wr_avail_busy got %b exp 1110", s_available); else passed++;
        checks++; if (m_wr !== 1'b0) $display("FAIL wr_early got %b exp 0", m_wr); else passed++;
        tick();
        checks++; if ({m_wr, m_rd} !== 2'b10) $display("FAIL wr_issue got %b exp 10", {m_wr, m_rd}); else passed++;
        checks++; if ({m_addr, m_data, m_byte_en} !== {21'h00123, 16'hBEEF, 2'b11})
            $display("FAIL wr_fields got %h/%h/%b exp 00123/beef/11", m_addr, m_data, m_byte_en); else passed++;
        tick();
        checks++; if (m_wr !== 1'b0) $display("FAIL wr_one_cycle got %b exp 0", m_wr); else passed++;
        m_ready = 1'b1;
        #1;
        checks++; if (s_ready !== 4'b0001) $display("FAIL wr_ready got %b exp 0001", s_ready); else passed++;
        tick();
        m_ready = 1'b0;
        checks++; if (s_available !== 4'hF) $display("FAIL wr_avail_back got %b exp 1111", s_available); else passed++;
        pend_m[0] = 0;
        last_m    = 0;
    endtask

    task automatic test_burst_read();
        bit ok;
        do_reset();
        strobe(2, 0, 1, 21'h1ABCD, 16'h0, 2'b00);
        tick();
        clear_strobes();
        wait_issue(ok);
        checks++; if (!ok || {m_rd, m_burst} !== 2'b11 || m_addr !== 21'h1ABCD)
            $display("FAIL burst_issue got rd/burst %b addr %h exp 11 1abcd", {m_rd, m_burst}, m_addr); else passed++;
        // A beat during the issue cycle must be ignored and not count toward the burst.
        m_ready = 1'b1;
        #1;
        checks++; if (s_ready !== 4'h0) $display("FAIL burst_ready_in_issue got %b exp 0000", s_ready); else passed++;
        tick();
        for (int b = 1; b <= BL; b++) begin
            m_ready = 1'b0;
            #1;
            checks++; if (s_ready !== 4'h0) $display("FAIL burst_gap got %b exp 0000", s_ready); else passed++;
            tick();
            m_ready = 1'b1;
            m_q     = QW'(b);
            #1;
            checks++; if (s_ready !== 4'b0100 || s_q !== QW'(b))
                $display("FAIL burst_beat%0d got ready %b q %0d exp 0100 %0d", b, s_ready, s_q, b); else passed++;
            tick();
        end
        m_ready = 1'b0;
        checks++; if (s_available !== 4'hF || m_rd !== 1'b0)
            $display("FAIL burst_done got avail %b rd %b exp 1111 0", s_available, m_rd); else passed++;
    endtask

    task automatic test_round_robin();
        bit ok;
        int exp_order [5] = '{0, 1, 2, 3, 1};
        do_reset();
        for (int p = 0; p < N; p++) strobe(p, 0, 0, AW'(p * 'h1000 + 'h55), DW'(p), 2'b01);
        tick();
        clear_strobes();
        for (int k = 0; k < 5; k++) begin
            int e = exp_order[k];
            wait_issue(ok);
            checks++; if (!ok || m_addr !== ex_addr[e])
                $display("FAIL rr_grant%0d got addr %h exp %h (port %0d)", k, m_addr, ex_addr[e], e); else passed++;
            tick();
            m_ready = 1'b1;
            m_q     = $urandom;
            #1;
            checks++; if (s_ready !== 4'(1 << e)) $display("FAIL rr_ready%0d got %b exp port %0d", k, s_ready, e); else passed++;
            tick();
            m_ready   = 1'b0;
            pend_m[e] = 0;
            if (k == 1) begin
                strobe(1, 0, 0, 21'h0AAAA, 16'h0, 2'b00);
                tick();
                clear_strobes();
            end
        end
        last_m = 1;
    endtask

    task automatic test_drop();
        int issues = 0;
        do_reset();
        strobe(1, 0, 0, 21'h00111, 16'h1111, 2'b01);
        tick();
        clear_strobes();
        checks++; if (s_available[1] !== 1'b0) $display("FAIL drop_busy got %b exp 0", s_available[1]); else passed++;
        strobe(1, 1, 0, 21'h00222, 16'h2222, 2'b10);
        tick();
        clear_strobes();
        checks++; if ({m_rd, m_wr} !== 2'b10 || m_addr !== 21'h00111)
            $display("FAIL drop_first got rd/wr %b addr %h exp 10 00111", {m_rd, m_wr}, m_addr); else passed++;
        tick();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        repeat (6) begin
            if (m_rd || m_wr) issues++;
            tick();
        end
        checks++; if (issues !== 0) $display("FAIL drop_extra got %0d issues exp 0", issues); else passed++;
    endtask

    task automatic test_m_available();
        int issues = 0;
        do_reset();
        m_available = 1'b0;
        strobe(3, 0, 0, 21'h00333, 16'h0, 2'b00);
        tick();
        clear_strobes();
        repeat (10) begin
            if (m_rd || m_wr) issues++;
            tick();
        end
        checks++; if (issues !== 0) $display("FAIL mavail_held got %0d issues exp 0", issues); else passed++;
        checks++; if (s_available !== 4'b0111) $display("FAIL mavail_capture got %b exp 0111", s_available); else passed++;
        m_available = 1'b1;
        #1;
        checks++; if (m_rd !== 1'b0) $display("FAIL mavail_early got %b exp 0", m_rd); else passed++;
        tick();
        checks++; if (m_rd !== 1'b1 || m_addr !== 21'h00333)
            $display("FAIL mavail_issue got rd %b addr %h exp 1 00333", m_rd, m_addr); else passed++;
        tick();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int stray = 0;
        do_reset();
        strobe(2, 0, 1, 21'h12345, 16'h0, 2'b00);
        tick();
        clear_strobes();
        wait_issue(ok);
        tick();
        m_ready = 1'b1;
        repeat (2) tick();
        m_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (s_available !== 4'hF || s_ready !== 4'h0 || {m_rd, m_wr, m_burst} !== 3'b000)
            $display("FAIL rstmid_outputs got avail %b ready %b strobes %b", s_available, s_ready,
                     {m_rd, m_wr, m_burst}); else passed++;
        checks++; if ({m_addr, m_data, m_byte_en} !== '0) $display("FAIL rstmid_fields got %h exp 0", m_addr); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        repeat (2) begin
            m_ready = 1'b1;
            #1;
            if (s_ready !== 4'h0 || m_rd || m_wr) stray++;
            tick();
        end
        m_ready = 1'b0;
        checks++; if (stray !== 0) $display("FAIL rstmid_stray got %0d responses exp 0", stray); else passed++;
        last_m = N - 1;
        for (int p = 0; p < N; p++) pend_m[p] = 0;
    endtask

    task automatic test_random();
        bit ok;
        do_reset();
        repeat (8) begin
            for (int p = 0; p < N; p++) begin
                if ($urandom % 2 == 0) strobe(p, 1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom), BW'($urandom));
            end
            tick();
            clear_strobes();
            while (rr_pick() >= 0) begin
                int w     = rr_pick();
                int beats = (ex_burst[w] && !ex_wr[w]) ? BL : 1;
                int got   = 0;
                int guard = 0;
                wait_issue(ok);
                checks++; if (!ok || m_addr !== ex_addr[w] || m_data !== ex_data[w] || m_byte_en !== ex_be[w])
                    $display("FAIL rand_fields got %h/%h/%b exp %h/%h/%b (port %0d)", m_addr, m_data, m_byte_en,
                             ex_addr[w], ex_data[w], ex_be[w], w); else passed++;
                checks++; if ({m_wr, m_rd, m_burst} !== {ex_wr[w], ~ex_wr[w], ex_burst[w]})
                    $display("FAIL rand_strobes got %b exp %b", {m_wr, m_rd, m_burst},
                             {ex_wr[w], ~ex_wr[w], ex_burst[w]}); else passed++;
                tick();
                while (got < beats && guard < 100) begin
                    logic [N-1:0] exp_ready;
                    guard++;
                    m_ready = ($urandom % 3 != 0);
                    m_q     = $urandom;
                    if ($urandom % 4 == 0) strobe($urandom % N, 1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom), BW'($urandom));
                    exp_ready = m_ready ? 4'(1 << w) : 4'h0;
                    #1;
                    checks++; if (s_ready !== exp_ready || s_q !== m_q)
                        $display("FAIL rand_ready got %b q %h exp %b q %h", s_ready, s_q, exp_ready, m_q); else passed++;
                    if (m_ready) got++;
                    tick();
                    clear_strobes();
                end
                m_ready   = 1'b0;
                pend_m[w] = 0;
                last_m    = w;
            end
        end
        tick();
        checks++; if (s_available !== 4'hF) $display("FAIL rand_drain got %b exp 1111", s_available); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_burst_read();
        test_round_robin();
        test_drop();
        test_m_available();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
